// File: rtl/lisp_memory_if.sv
// Request/response bundle for the lisp_memory heap store.
// Built with LISP_MEM_PARITY_EN defined, the bundle also carries parity_err.
interface lisp_memory_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 17
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  init_done;
`ifdef LISP_MEM_PARITY_EN
   logic                  parity_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, init_done, parity_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, init_done, parity_err
   );
`else
   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, init_done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, init_done
   );
`endif
endinterface

// File: rtl/lisp_memory.sv
// lisp_memory: word memory for the Lisp heap and cons store.
// After every reset the whole array is filled with INIT_VALUE, one word per
// cycle. The block then accepts one read or write per cycle. Read data comes
// back READ_LATENCY cycles after acceptance, and the response has no
// backpressure.
// Optional feature macro LISP_MEM_PARITY_EN: each stored word gains an even
// parity bit, and parity_err flags a read whose parity does not check.
module lisp_memory #(
   parameter int                    ADDR_WIDTH   = 8,
   parameter int                    DATA_WIDTH   = 17,
   parameter int                    READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input logic          clk,
   input logic          rst,
   lisp_memory_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef LISP_MEM_PARITY_EN
   localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
   localparam int WORD_WIDTH = DATA_WIDTH;
`endif

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_latency_check
      $error("lisp_memory: READ_LATENCY must lie within 1..4");
   end

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic [ADDR_WIDTH-1:0]   cnt_d;
   logic                    init_done_q;

   logic [WORD_WIDTH-1:0]   mem [DEPTH];
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [WORD_WIDTH-1:0]   mem_wdata;

   logic                    accept;
   logic                    rd_accept;
   logic [WORD_WIDTH-1:0]   data_pipe [READ_LATENCY];
   logic [READ_LATENCY-1:0] valid_pipe;

   // Attach the parity bit, if there is one, to a data word before it is stored
   function automatic logic [WORD_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] data);
`ifdef LISP_MEM_PARITY_EN
      encode = {^data, data};
`else
      encode = data;
`endif
   endfunction

   assign accept    = bus.req_valid && init_done_q;
   assign rd_accept = accept && !bus.req_write;

   // State register: clear counter, CLEAR/RUN state and the registered ready flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= (state_d == RUN);
      end
   end

   // CLEAR sweeps every address once, writing INIT_VALUE. RUN passes accepted writes to the array
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = bus.req_addr;
      mem_wdata = encode(bus.req_wdata);
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = encode(INIT_VALUE);
            cnt_d     = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept && bus.req_write) begin
               mem_we = 1'b1;
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // Array write port. There is no reset here, so the array can map onto block RAM
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Read pipeline: read the array at acceptance, then move data forward only behind a valid, so the output holds between responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_pipe <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            data_pipe[i] <= '0;
         end
      end else begin
         valid_pipe[0] <= rd_accept;
         if (rd_accept) begin
            data_pipe[0] <= mem[bus.req_addr];
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
            if (valid_pipe[i-1]) begin
               data_pipe[i] <= data_pipe[i-1];
            end
         end
      end
   end

   assign bus.req_ready = init_done_q;
   assign bus.init_done = init_done_q;
   assign bus.rsp_valid = valid_pipe[READ_LATENCY-1];
   assign bus.rsp_rdata = data_pipe[READ_LATENCY-1][DATA_WIDTH-1:0];
`ifdef LISP_MEM_PARITY_EN
   assign bus.parity_err = valid_pipe[READ_LATENCY-1] &&
                           ((^data_pipe[READ_LATENCY-1][DATA_WIDTH-1:0]) !=
                            data_pipe[READ_LATENCY-1][DATA_WIDTH]);
`endif
endmodule

// File: tb/tb_lisp_memory.sv
// Testbench for lisp_memory. The same request stream drives three instances
// with READ_LATENCY 1, 2 and 3. A reference model holds the memory contents
// as a plain array and keeps pending responses as (due edge, data) entries.
module tb_lisp_memory;
   localparam int              AW    = 4;
   localparam int              DW    = 17;
   localparam int              DEPTH = 16;
   localparam int              NDUT  = 3;
   localparam logic [DW-1:0]   INIT  = 17'h00005;

   typedef struct {
      int            due;
      int            unit;
      logic [DW-1:0] data;
      bit            perr;
   } pend_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int checks_total  = 0;
   int checks_passed = 0;
   int checks_failed = 0;

   logic [DW-1:0] exp_mem [DEPTH];
   bit            corrupt [DEPTH];
   logic [DW-1:0] last_data [NDUT];
   int            lat [NDUT] = '{1, 2, 3};
   pend_t         pend [$];
   int            edge_no = 0;
   int            edges_since_release = 0;
   bit            model_ready = 1'b0;

   always #5 clk = ~clk;

   lisp_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 (), bus2 (), bus3 ();

   lisp_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .INIT_VALUE(INIT)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   lisp_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .INIT_VALUE(INIT)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   lisp_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3), .INIT_VALUE(INIT)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   task automatic compare(input string tag, input int unit,
                          input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checks_total++;
      assert (observed === expected) checks_passed++;
      else begin
         checks_failed++;
         $error("[TB] FAIL %s dut%0d observed=%h expected=%h", tag, unit + 1, observed, expected);
      end
   endtask

   // Compare every output of all three instances with the model for the current edge
   task automatic checkOutput();
      logic [NDUT-1:0] ov;
      logic [NDUT-1:0] ordy;
      logic [NDUT-1:0] odone;
      logic [NDUT-1:0] operr;
      logic [DW-1:0]   odata [NDUT];
      bit              exp_v;
      bit              exp_perr;
      ov       = {bus3.rsp_valid, bus2.rsp_valid, bus1.rsp_valid};
      ordy     = {bus3.req_ready, bus2.req_ready, bus1.req_ready};
      odone    = {bus3.init_done, bus2.init_done, bus1.init_done};
      odata[0] = bus1.rsp_rdata;
      odata[1] = bus2.rsp_rdata;
      odata[2] = bus3.rsp_rdata;
`ifdef LISP_MEM_PARITY_EN
      operr    = {bus3.parity_err, bus2.parity_err, bus1.parity_err};
`else
      operr    = '0;
`endif
      for (int i = 0; i < NDUT; i++) begin
         exp_v    = 1'b0;
         exp_perr = 1'b0;
         for (int j = 0; j < pend.size(); j++) begin
            if (pend[j].unit == i && pend[j].due == edge_no) begin
               exp_v        = 1'b1;
               exp_perr     = pend[j].perr;
               last_data[i] = pend[j].data;
               pend.delete(j);
               break;
            end
         end
         compare("rsp_valid", i, DW'(ov[i]), DW'(exp_v));
         compare("rsp_rdata", i, odata[i], last_data[i]);
         compare("req_ready", i, DW'(ordy[i]), DW'(model_ready));
         compare("init_done", i, DW'(odone[i]), DW'(model_ready));
`ifdef LISP_MEM_PARITY_EN
         compare("parity_err", i, DW'(operr[i]), DW'(exp_perr));
`else
         if (operr[i] || exp_perr) begin
            compare("parity_err", i, DW'(operr[i]), DW'(exp_perr));
         end
`endif
      end
   endtask

   // Drive one request for one cycle, advance the model across the edge, then check
   task automatic applyStimulus(input bit v, input bit w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = a; bus1.req_wdata = d;
      bus2.req_valid = v; bus2.req_write = w; bus2.req_addr = a; bus2.req_wdata = d;
      bus3.req_valid = v; bus3.req_write = w; bus3.req_addr = a; bus3.req_wdata = d;
      @(posedge clk);
      edge_no++;
      if (v && model_ready) begin
         if (w) begin
            exp_mem[a] = d;
            corrupt[a] = 1'b0;
         end else begin
            for (int i = 0; i < NDUT; i++) begin
               pend.push_back(pend_t'{edge_no + lat[i] - 1, i, exp_mem[a], corrupt[a]});
            end
         end
      end
      edges_since_release++;
      model_ready = (edges_since_release >= DEPTH);
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
      end
   endtask

   // Assert reset away from any edge. Outputs must fall at once, and the model forgets in-flight reads
   task automatic doReset(input int n);
      rst = 1'b1;
      #1;
      pend.delete();
      model_ready         = 1'b0;
      edges_since_release = 0;
      for (int i = 0; i < NDUT; i++) begin
         last_data[i] = '0;
      end
      for (int a = 0; a < DEPTH; a++) begin
         exp_mem[a] = INIT;
         corrupt[a] = 1'b0;
      end
      checkOutput();
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
      bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
      bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
      #2;
      $display("[TB] reset and clear sequence");
      doReset(2);

      // Write attempts during CLEAR must be ignored. Ready rises after exactly DEPTH edges.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b1, 4'd0, 17'h1FFFF);
      end
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
      end

      $display("[TB] read back the cleared array");
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b1, 1'b0, AW'(a), DW'($urandom));
      end
      idle(4);

      $display("[TB] write then read the same address on the next cycle");
      applyStimulus(1'b1, 1'b1, 4'd3, 17'h02A2A);
      applyStimulus(1'b1, 1'b0, 4'd3, '0);
      idle(4);

      $display("[TB] back-to-back reads");
      for (int a = 0; a < 4; a++) begin
         applyStimulus(1'b1, 1'b1, AW'(a), DW'(10 + a));
      end
      for (int a = 0; a < 4; a++) begin
         applyStimulus(1'b1, 1'b0, AW'(a), '0);
      end
      idle(4);

      $display("[TB] random traffic");
      for (int k = 0; k < 150; k++) begin
         applyStimulus(($urandom_range(3, 0) != 0), 1'($urandom), AW'($urandom), DW'($urandom));
      end
      idle(4);

      $display("[TB] reset with reads in flight");
      applyStimulus(1'b1, 1'b1, 4'd9, 17'h1ABCD);
      applyStimulus(1'b1, 1'b0, 4'd9, '0);
      applyStimulus(1'b1, 1'b0, 4'd3, '0);
      doReset(3);
      idle(DEPTH);
      applyStimulus(1'b1, 1'b0, 4'd9, '0);
      applyStimulus(1'b1, 1'b0, 4'd3, '0);
      applyStimulus(1'b1, 1'b0, 4'd0, '0);
      idle(4);
      for (int k = 0; k < 40; k++) begin
         ra = AW'($urandom);
         rd = DW'($urandom);
         applyStimulus(1'b1, 1'($urandom), ra, rd);
      end
      idle(4);

`ifdef LISP_MEM_PARITY_EN
      $display("[TB] corrupt a stored bit and read it back");
      applyStimulus(1'b1, 1'b1, 4'd5, 17'h0F0F0);
      applyStimulus(1'b1, 1'b1, 4'd6, 17'h13579);
      dut1.mem[5][0] = ~dut1.mem[5][0];
      dut2.mem[5][0] = ~dut2.mem[5][0];
      dut3.mem[5][0] = ~dut3.mem[5][0];
      exp_mem[5][0]  = ~exp_mem[5][0];
      corrupt[5]     = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'd5, '0);
      applyStimulus(1'b1, 1'b0, 4'd6, '0);
      applyStimulus(1'b1, 1'b0, 4'd5, '0);
      idle(4);
      applyStimulus(1'b1, 1'b1, 4'd5, 17'h00011);
      applyStimulus(1'b1, 1'b0, 4'd5, '0);
      idle(4);
`endif

      if (pend.size() != 0) begin
         compare("undelivered_responses", 0, DW'(pend.size()), '0);
      end
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
